// File: rtl/cpu_multicycle.sv
// Multicycle 32-bit-instruction core: FETCH -> DECODE -> EXECUTE -> WRITEBACK, halting on illegal opcodes.
// Register file and PC are cleared asynchronously; operand/result latches carry no reset.
module cpu_multicycle #(
  parameter int DATA_W = 8,
  parameter int NREG   = 8,
  localparam int AW    = $clog2(NREG)
) (
  input  logic              CLK,
  input  logic              RESET,
  output logic [31:0]       PC,
  output logic              INSTR_READ,
  input  logic [31:0]       INSTRUCTION,
  input  logic              INSTR_BUSYWAIT,
  output logic              HALTED,
  input  logic [AW-1:0]     DBG_ADDR,
  output logic [DATA_W-1:0] DBG_DATA
);

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXECUTE,
    S_WRITEBACK,
    S_HALT
  } state_t;

  state_t                   r_state;
  logic [31:0]              r_pc;
  logic [31:0]              r_ir;
  logic                     r_instr_read;
  logic                     r_halted;
  logic [DATA_W-1:0]        r_regs [NREG];
  logic signed [DATA_W-1:0] r_a_p1;
  logic signed [DATA_W-1:0] r_b_p1;
  logic signed [DATA_W-1:0] r_imm_p1;
  logic signed [DATA_W-1:0] r_res_p2;
  logic [31:0]              r_npc_p2;

  logic [7:0]               w_op;
  logic [AW-1:0]            w_dest;
  logic [AW-1:0]            w_src1;
  logic [AW-1:0]            w_src2;
  logic                     w_legal;
  logic                     w_taken;
  logic [31:0]              w_off_ext;
  logic [31:0]              w_npc;
  logic signed [DATA_W-1:0] w_imm;

  assign w_op      = r_ir[31:24];
  assign w_dest    = r_ir[16 +: AW];
  assign w_src1    = r_ir[8 +: AW];
  assign w_src2    = r_ir[0 +: AW];
  assign w_legal   = (w_op <= 8'h07);
  assign w_imm     = DATA_W'($signed(r_ir[7:0]));
  assign w_off_ext = {{24{r_ir[23]}}, r_ir[23:16]};
  assign w_taken   = (w_op == 8'h06) || ((w_op == 8'h07) && (r_a_p1 == r_b_p1));
  assign w_npc     = r_pc + 32'd4 + (w_taken ? {w_off_ext[29:0], 2'b00} : 32'd0);

  assign PC         = r_pc;
  assign INSTR_READ = r_instr_read;
  assign HALTED     = r_halted;
  assign DBG_DATA   = r_regs[DBG_ADDR];

  function automatic logic signed [DATA_W-1:0] f_alu(
    input logic [7:0]               op,
    input logic signed [DATA_W-1:0] a,
    input logic signed [DATA_W-1:0] b,
    input logic signed [DATA_W-1:0] imm
  );
    case (op)
      8'h00:   f_alu = imm;
      8'h01:   f_alu = b;
      8'h02:   f_alu = a + b;
      8'h03:   f_alu = DATA_W'(a + ~b + 1);
      8'h04:   f_alu = a & b;
      8'h05:   f_alu = a | b;
      default: f_alu = '0;
    endcase
  endfunction

  // p1: operand latch in DECODE; p2: ALU result and next PC in EXECUTE
  always_ff @(posedge CLK) begin
    case (r_state)
      S_DECODE: begin
        r_a_p1   <= r_regs[w_src1];
        r_b_p1   <= r_regs[w_src2];
        r_imm_p1 <= w_imm;
      end
      S_EXECUTE: begin
        r_res_p2 <= f_alu(w_op, r_a_p1, r_b_p1, r_imm_p1);
        r_npc_p2 <= w_npc;
      end
      default: ;
    endcase
  end

  // After reset the first FETCH cycle only raises the read request; the word is taken on the next edge.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_state      <= S_FETCH;
      r_pc         <= '0;
      r_ir         <= '0;
      r_instr_read <= 1'b0;
      r_halted     <= 1'b0;
      for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
    end else begin
      case (r_state)
        S_FETCH: begin
          if (!r_instr_read) begin
            r_instr_read <= 1'b1;
          end else if (!INSTR_BUSYWAIT) begin
            r_ir         <= INSTRUCTION;
            r_instr_read <= 1'b0;
            r_state      <= S_DECODE;
          end
        end
        S_DECODE: begin
          if (w_legal) begin
            r_state  <= S_EXECUTE;
          end else begin
            r_state  <= S_HALT;
            r_halted <= 1'b1;
          end
        end
        S_EXECUTE: r_state <= S_WRITEBACK;
        S_WRITEBACK: begin
          if (w_op <= 8'h05) r_regs[w_dest] <= r_res_p2;
          r_pc         <= r_npc_p2;
          r_instr_read <= 1'b1;
          r_state      <= S_FETCH;
        end
        S_HALT: ;
        default: r_state <= S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_multicycle.sv
// Bench for cpu_multicycle: an instruction-level model with cycle timing (CPI 4, +1 per busy cycle)
// checked every cycle, plus hand-computed literal expectations for the reference programs.
module tb_cpu_multicycle;
  localparam int DW = 8;
  localparam int NR = 8;
  localparam int AW = 3;
  localparam logic [31:0] MASK = (32'd1 << DW) - 32'd1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          busy;
  logic [AW-1:0] dbg_addr;
  logic [AW-1:0] dbg16_addr;
  logic [31:0]   instr, instr16;
  logic [31:0]   pc, pc16;
  logic          ird, ird16, halted, halted16;
  logic [DW-1:0] dbg_data;
  logic [15:0]   dbg16_data;
  logic [31:0]   imem [64];

  always #5 clk = ~clk;

  assign instr   = imem[pc[7:2]];
  assign instr16 = imem[pc16[7:2]];

  cpu_multicycle #(.DATA_W(DW), .NREG(NR)) dut (
    .CLK(clk), .RESET(rst_n), .PC(pc), .INSTR_READ(ird), .INSTRUCTION(instr),
    .INSTR_BUSYWAIT(busy), .HALTED(halted), .DBG_ADDR(dbg_addr), .DBG_DATA(dbg_data)
  );

  cpu_multicycle #(.DATA_W(16), .NREG(NR)) dut16 (
    .CLK(clk), .RESET(rst_n), .PC(pc16), .INSTR_READ(ird16), .INSTRUCTION(instr16),
    .INSTR_BUSYWAIT(busy), .HALTED(halted16), .DBG_ADDR(dbg16_addr), .DBG_DATA(dbg16_data)
  );

  int tests = 0;
  int fails = 0;
  logic cmp_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] enc(input logic [7:0] op, input logic [7:0] d,
                                      input logic [7:0] s1, input logic [7:0] s2);
    return {op, d, s1, s2};
  endfunction

  function automatic logic [31:0] sx8(input logic [7:0] v);
    return {{24{v[7]}}, v};
  endfunction

  // Reference model: tracks an in-flight instruction by its age in edges since it was taken.
  logic [31:0] m_pc, m_ir, m_a, m_b, m_nxt;
  logic [31:0] m_regs [NR];
  logic        m_read, m_halt;
  logic [7:0]  m_op;
  int          m_age;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pc = 0; m_ir = 0; m_read = 0; m_halt = 0; m_age = -1;
      for (int i = 0; i < NR; i++) m_regs[i] = 0;
    end else if (!m_halt) begin
      if (m_age >= 0) begin
        m_age++;
        m_op = m_ir[31:24];
        if (m_age == 1 && m_op > 8'h07) begin
          m_halt = 1; m_age = -1;
        end else if (m_age == 3) begin
          m_a   = m_regs[m_ir[8 +: AW]];
          m_b   = m_regs[m_ir[0 +: AW]];
          m_nxt = m_pc + 32'd4;
          case (m_op)
            8'h00: m_regs[m_ir[16 +: AW]] = sx8(m_ir[7:0]) & MASK;
            8'h01: m_regs[m_ir[16 +: AW]] = m_b;
            8'h02: m_regs[m_ir[16 +: AW]] = (m_a + m_b) & MASK;
            8'h03: m_regs[m_ir[16 +: AW]] = (m_a - m_b) & MASK;
            8'h04: m_regs[m_ir[16 +: AW]] = m_a & m_b;
            8'h05: m_regs[m_ir[16 +: AW]] = m_a | m_b;
            8'h06: m_nxt = m_nxt + (sx8(m_ir[23:16]) << 2);
            default: if (m_a == m_b) m_nxt = m_nxt + (sx8(m_ir[23:16]) << 2);
          endcase
          m_pc = m_nxt; m_age = -1; m_read = 1;
        end
      end else if (!m_read) begin
        m_read = 1;
      end else if (!busy) begin
        m_ir = imem[m_pc[7:2]]; m_read = 0; m_age = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("cyc_pc", pc, m_pc);
      chk("cyc_instr_read", {31'd0, ird}, {31'd0, m_read});
      chk("cyc_halted", {31'd0, halted}, {31'd0, m_halt});
      chk("cyc_dbg_data", {24'd0, dbg_data}, m_regs[dbg_addr]);
    end
  end

  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic hold_reset();
    @(posedge clk);
    #2 rst_n = 1'b0;
    for (int i = 0; i < 64; i++) imem[i] = 32'hFF00_0000;
  endtask

  task automatic start();
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic load_p1();
    imem[0]  = enc(8'h00, 8'd4, 8'd0, 8'd5);
    imem[1]  = enc(8'h00, 8'd2, 8'd0, 8'd9);
    imem[2]  = enc(8'h02, 8'd6, 8'd4, 8'd2);
    imem[3]  = enc(8'h03, 8'd1, 8'd4, 8'd2);
    imem[4]  = enc(8'h00, 8'd3, 8'd0, 8'h80);
    imem[5]  = enc(8'h04, 8'd5, 8'd4, 8'd2);
    imem[6]  = enc(8'h05, 8'd7, 8'd4, 8'd2);
    imem[7]  = enc(8'h01, 8'd0, 8'd0, 8'd6);
    imem[8]  = enc(8'h06, 8'd1, 8'd0, 8'd0);
    imem[9]  = enc(8'h00, 8'd0, 8'd0, 8'h55);
  endtask

  int rd_cnt;

  initial begin
    rst_n = 1'b1; busy = 1'b0; dbg_addr = '0; dbg16_addr = 3'd3;
    for (int i = 0; i < 64; i++) imem[i] = 32'hFF00_0000;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_pc", pc, 32'd0);
    chk("rst_instr_read", {31'd0, ird}, 32'd0);
    chk("rst_halted", {31'd0, halted}, 32'd0);
    chk("rst_dbg", {24'd0, dbg_data}, 32'd0);
    cmp_en = 1'b1;

    // Program 1: loadi/loadi/add, then sub, and, or, mov, jump over a loadi into a halt.
    load_p1();
    dbg_addr = 3'd6;
    start();
    edges(12);
    chk("p1_pc_after_12", pc, 32'd12);
    chk("p1_r6_add", {24'd0, dbg_data}, 32'h0E);
    edges(33);
    chk("p1_halted", {31'd0, halted}, 32'd1);
    chk("p1_pc_halt", pc, 32'd40);
    dbg_addr = 3'd1; #1 chk("p1_r1_sub", {24'd0, dbg_data}, 32'hFC);
    dbg_addr = 3'd3; #1 chk("p1_r3_imm8", {24'd0, dbg_data}, 32'h80);
    dbg_addr = 3'd5; #1 chk("p1_r5_and", {24'd0, dbg_data}, 32'h01);
    dbg_addr = 3'd7; #1 chk("p1_r7_or", {24'd0, dbg_data}, 32'h0D);
    dbg_addr = 3'd0; #1 chk("p1_r0_mov_not_skipped", {24'd0, dbg_data}, 32'h0E);
    chk("p1_w16_r3_sext", {16'd0, dbg16_data}, 32'hFF80);

    // beq taken: r1 == r2 at PC 8 jumps to 16
    hold_reset();
    imem[0] = enc(8'h00, 8'd1, 8'd0, 8'd7);
    imem[1] = enc(8'h00, 8'd2, 8'd0, 8'd7);
    imem[2] = enc(8'h07, 8'd1, 8'd1, 8'd2);
    imem[3] = enc(8'h00, 8'd5, 8'd0, 8'h11);
    dbg_addr = 3'd5;
    start();
    edges(12);
    chk("beq_taken_pc", pc, 32'd16);
    edges(5);
    chk("beq_taken_halt_pc", pc, 32'd16);
    chk("beq_taken_r5", {24'd0, dbg_data}, 32'd0);

    // beq not taken: r2 = 6
    hold_reset();
    imem[0] = enc(8'h00, 8'd1, 8'd0, 8'd7);
    imem[1] = enc(8'h00, 8'd2, 8'd0, 8'd6);
    imem[2] = enc(8'h07, 8'd1, 8'd1, 8'd2);
    dbg_addr = 3'd1;
    start();
    edges(12);
    chk("beq_nt_pc", pc, 32'd12);
    edges(5);
    chk("beq_nt_halted", {31'd0, halted}, 32'd1);
    chk("beq_nt_r1_kept", {24'd0, dbg_data}, 32'd7);
    dbg_addr = 3'd2; #1 chk("beq_nt_r2", {24'd0, dbg_data}, 32'd6);

    // Three busy cycles in the first fetch
    hold_reset();
    imem[0] = enc(8'h00, 8'd3, 8'd0, 8'h21);
    busy = 1'b1;
    dbg_addr = 3'd3;
    rd_cnt = 0;
    start();
    repeat (4) begin
      @(negedge clk);
      if (ird && pc == 32'd0) rd_cnt++;
    end
    busy = 1'b0;
    edges(3);
    chk("busy_r3_at_6", {24'd0, dbg_data}, 32'd0);
    edges(1);
    chk("busy_r3_at_7", {24'd0, dbg_data}, 32'h21);
    chk("busy_read_cycles", rd_cnt, 32'd4);
    chk("busy_pc_after", pc, 32'd4);

    // Illegal opcode at PC 4
    hold_reset();
    imem[0] = enc(8'h00, 8'd2, 8'd0, 8'h33);
    dbg_addr = 3'd2;
    start();
    edges(5);
    chk("ill_not_yet_halted", {31'd0, halted}, 32'd0);
    edges(1);
    chk("ill_halted", {31'd0, halted}, 32'd1);
    chk("ill_pc", pc, 32'd4);
    chk("ill_instr_read", {31'd0, ird}, 32'd0);
    chk("ill_r2", {24'd0, dbg_data}, 32'h33);
    edges(5);
    chk("ill_pc_held", pc, 32'd4);
    chk("ill_still_halted", {31'd0, halted}, 32'd1);

    // Asynchronous reset during EXECUTE of add r6
    hold_reset();
    load_p1();
    dbg_addr = 3'd4;
    start();
    edges(10);
    rst_n = 1'b0;
    #1;
    chk("arst_pc", pc, 32'd0);
    chk("arst_r4", {24'd0, dbg_data}, 32'd0);
    chk("arst_instr_read", {31'd0, ird}, 32'd0);
    dbg_addr = 3'd6; #1 chk("arst_r6", {24'd0, dbg_data}, 32'd0);
    start();
    edges(12);
    chk("arst_restart_pc", pc, 32'd12);
    chk("arst_restart_r6", {24'd0, dbg_data}, 32'h0E);

    cmp_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule

// File: doc/cpu_multicycle.md
CPU_MULTICYCLE -- requirements
Module: cpu_multicycle

Interface
REQ-001 Parameter DATA_W, default 8, SHALL set the datapath and register width in bits (8..32).
REQ-002 Parameter NREG, default 8, SHALL set the register count (power of 2, 2..256); AW = log2(NREG).
REQ-003 CLK  input  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-004 RESET  input  1  SHALL be an asynchronous, active-low reset (asserted at 0).
REQ-005 PC  output  32  SHALL be the address of the instruction being fetched or executed.
REQ-006 INSTR_READ  output  1  SHALL request an instruction fetch at address PC.
REQ-007 INSTRUCTION  input  32  SHALL be the fetched word: OPCODE[31:24], DEST/OFFSET[23:16], SRC1[15:8], SRC2/IMM[7:0].
REQ-008 INSTR_BUSYWAIT  input  1  SHALL indicate that memory has not yet delivered INSTRUCTION.
REQ-009 HALTED  output  1  SHALL indicate that the core has stopped on an illegal opcode.
REQ-010 DBG_ADDR  input  AW  SHALL select a register for debug read.
REQ-011 DBG_DATA  output  DATA_W  SHALL combinationally return register[DBG_ADDR].

Function
REQ-012 The FSM SHALL have the states FETCH, DECODE, EXECUTE, WRITEBACK and HALT; one transition per clock edge.
REQ-013 FETCH SHALL drive INSTR_READ=1, otherwise INSTR_READ=0; on an edge with INSTR_BUSYWAIT=0, IR<=INSTRUCTION and the FSM moves to DECODE; while INSTR_BUSYWAIT=1 it stays in FETCH with PC held.
REQ-014 DECODE SHALL latch A<=reg[SRC1], B<=reg[SRC2] (low AW bits of each field), and IMM sign-extended to DATA_W, then move to EXECUTE; an illegal opcode SHALL move to HALT instead.
REQ-015 Opcodes SHALL be: 0x00 loadi (R=IMM), 0x01 mov (R=B), 0x02 add (R=A+B), 0x03 sub (R=A+~B+1), 0x04 and, 0x05 or, 0x06 j, 0x07 beq; all others are illegal.
REQ-016 Arithmetic SHALL wrap modulo 2^DATA_W; there are no flags other than the internal zero compare.
REQ-017 EXECUTE SHALL register R and compute NPC = PC+4, or, for j or for beq with A==B, PC+4+(sext(OFFSET[23:16])<<2); PC arithmetic wraps modulo 2^32.
REQ-018 WRITEBACK SHALL write reg[DEST low AW bits]<=R for opcodes 0x00-0x05, set PC<=NPC, and return to FETCH; j and beq SHALL NOT write any register.
REQ-019 Register 0 SHALL be an ordinary writable register.
REQ-020 Zero-wait CPI SHALL be 4; each cycle of INSTR_BUSYWAIT adds exactly 1 cycle.
REQ-021 HALT SHALL hold PC, the registers and INSTR_READ=0, and SHALL set HALTED=1 until reset.
REQ-022 DBG_DATA SHALL reflect a WRITEBACK write from the edge on which the write occurs.

Reset
REQ-023 RESET=0 SHALL immediately, without waiting for a clock edge, force PC=0, all registers=0, IR=0, FSM=FETCH, HALTED=0 and INSTR_READ=0.
REQ-024 While RESET=0, INSTR_READ SHALL remain 0; the first FETCH with INSTR_READ=1 SHALL begin on the first rising edge after RESET returns to 1.
REQ-025 A reset asserted in any state, including mid-fetch with INSTR_BUSYWAIT=1, SHALL abort the instruction with no register or PC update.

Verification
REQ-026 Defaults, zero-wait memory, loadi r4,5; loadi r2,9; add r6,r4,r2 -> after 12 post-reset cycles r6=14 (0x0E) and PC=12.
REQ-027 loadi r4,5; loadi r2,9; sub r1,r4,r2 -> r1=0xFC; with DATA_W=16, loadi r3,0x80 -> r3=0xFF80.
REQ-028 loadi r1,7; loadi r2,7; beq +1,r1,r2 at PC=8 -> next fetch at PC=16; with r2=6 instead -> next fetch at PC=12, no register written.
REQ-029 INSTR_BUSYWAIT held 1 for 3 cycles in FETCH -> INSTR_READ=1 for 4 cycles, PC stable, that instruction completes in 7 cycles.
REQ-030 Opcode 0xFF at PC=4 -> HALTED=1 one edge after DECODE, PC stays 4, INSTR_READ=0, registers unchanged.
REQ-031 RESET driven low between clock edges during EXECUTE of add r6 -> PC=0 and DBG_DATA(r6)=0 immediately; execution restarts at PC=0 after release.
